// File: rtl/matrix_bcm.sv
// matrix_bcm: RGB LED matrix driver for 74HC595 chains. A Wishbone slave holds
// one {B,G,R} pixel word per LED; the scan engine shifts one row word at a time
// and uses binary-code modulation (plane b held HOLD_BASE<<b cycles).
module matrix_bcm #(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int COLOR_BITS    = 4,
    parameter int HOLD_BASE     = 64,
    parameter int DIV_W         = 8,
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = $clog2(ROWS*COLS),
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH/8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DIV_W-1:0]         i_clk_div,
    input  logic                     i_mode,
    output logic                     o_matrix_clk,
    output logic                     o_matrix_latch,
    output logic                     o_matrix_mosi,
    output logic                     o_frame_done,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
    input  logic [WB_DATA_WIDTH-1:0] i_wb_wdata,
    output logic                     o_wb_ack,
    output logic                     o_wb_stall,
    output logic [WB_DATA_WIDTH-1:0] o_wb_rdata
);
    localparam int NPIX = ROWS * COLS;
    localparam int PW   = 3 * COLOR_BITS;
    localparam int LEN  = 3 * COLS + ROWS;
    localparam int RW   = $clog2(ROWS);
    localparam int PLW  = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int BW   = $clog2(LEN + 1);
    localparam int HW   = $clog2(HOLD_BASE << (COLOR_BITS - 1)) + 1;

    typedef enum logic [2:0] {BLANK, LOAD, SHIFT, LATCH, HOLD} state_t;

    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [PW-1:0] mem [NPIX];
    logic        addr_ok;
    logic        unused;

    state_t          state;
    logic [LEN-1:0]  shreg;
    logic [LEN-1:0]  load_word;
    logic [BW-1:0]   bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_q;
    logic            half;
    logic [1:0]      lph;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_len;
    logic [RW-1:0]   row;
    logic [PLW-1:0]  plane;
    logic [1:0]      colour;
    logic            mode_q;
    logic            blank_pass;
    logic            tick;
    logic            row_start;
    logic            mode_eff;

    assign o_wb_stall = 1'b0;
    assign addr_ok    = int'(i_wb_addr) < NPIX;
    assign unused     = ^{i_wb_wdata, i_wb_sel};

    assign tick      = (div_cnt == div_q);
    assign row_start = (plane == '0) && (colour == 2'd0);
    // mode/divider take effect only when a new row begins
    assign mode_eff  = row_start ? i_mode : mode_q;
    assign hold_len  = HW'(HOLD_BASE) << plane;

    // reset asserts asynchronously, releases two clocks after reset_n rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Wishbone slave: ack every request next cycle, byte-masked pixel writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) mem[i] <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_rdata <= '0;
        end else begin
            o_wb_ack <= i_wb_cyc && i_wb_stb;
            if (i_wb_cyc && i_wb_stb) begin
                o_wb_rdata <= '0;
                if (addr_ok) begin
                    if (i_wb_we) begin
                        for (int b = 0; b < PW; b++)
                            if (i_wb_sel[b/8]) mem[i_wb_addr][b] <= i_wb_wdata[b];
                    end else begin
                        o_wb_rdata <= WB_DATA_WIDTH'(mem[i_wb_addr]);
                    end
                end
            end
        end
    end

    // row word for current (row, plane, colour); bit 0 leaves first, colours active-low
    always_comb begin
        load_word = '0;
        for (int c = 0; c < COLS; c++) begin
            load_word[c]        = !(mem[int'(row)*COLS + c][int'(plane)] &&
                                    (mode_eff || colour == 2'd0));
            load_word[COLS+c]   = !(mem[int'(row)*COLS + c][2*COLOR_BITS + int'(plane)] &&
                                    (mode_eff || colour == 2'd1));
            load_word[2*COLS+c] = !(mem[int'(row)*COLS + c][COLOR_BITS + int'(plane)] &&
                                    (mode_eff || colour == 2'd2));
        end
        for (int r = 0; r < ROWS; r++) load_word[3*COLS + r] = (r == int'(row));
    end

    // scan engine: blank word once, then shift/latch/hold per (row, plane, colour)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BLANK;
            shreg          <= '0;
            bit_cnt        <= '0;
            div_cnt        <= '0;
            div_q          <= '0;
            half           <= 1'b0;
            lph            <= '0;
            hold_cnt       <= '0;
            row            <= '0;
            plane          <= '0;
            colour         <= '0;
            mode_q         <= 1'b0;
            blank_pass     <= 1'b0;
            o_matrix_clk   <= 1'b0;
            o_matrix_latch <= 1'b0;
            o_matrix_mosi  <= 1'b1;
            o_frame_done   <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            div_cnt      <= tick ? '0 : div_cnt + DIV_W'(1);
            case (state)
                BLANK: begin
                    div_q      <= i_clk_div;
                    mode_q     <= i_mode;
                    shreg      <= {{ROWS{1'b0}}, {(3*COLS){1'b1}}};
                    bit_cnt    <= '0;
                    half       <= 1'b0;
                    div_cnt    <= '0;
                    blank_pass <= 1'b1;
                    state      <= SHIFT;
                end
                LOAD: begin
                    if (row_start) begin
                        div_q  <= i_clk_div;
                        mode_q <= i_mode;
                    end
                    shreg   <= load_word;
                    bit_cnt <= '0;
                    half    <= 1'b0;
                    div_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: if (tick) begin
                    if (!half) begin
                        o_matrix_mosi <= shreg[0];
                        o_matrix_clk  <= 1'b0;
                        half          <= 1'b1;
                    end else begin
                        o_matrix_clk <= 1'b1;
                        half         <= 1'b0;
                        shreg        <= shreg >> 1;
                        bit_cnt      <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(LEN - 1)) begin
                            lph   <= '0;
                            state <= LATCH;
                        end
                    end
                end
                LATCH: if (tick) begin
                    case (lph)
                        2'd0: begin
                            o_matrix_clk   <= 1'b0;
                            o_matrix_latch <= 1'b1;
                            lph            <= 2'd1;
                        end
                        2'd1: begin
                            o_matrix_latch <= 1'b0;
                            lph            <= 2'd2;
                        end
                        default: begin
                            lph <= '0;
                            if (blank_pass) begin
                                blank_pass <= 1'b0;
                                state      <= LOAD;
                            end else begin
                                hold_cnt <= '0;
                                state    <= HOLD;
                            end
                        end
                    endcase
                end
                HOLD: begin
                    if (hold_cnt == hold_len - HW'(1)) begin
                        state <= LOAD;
                        if (!mode_q && colour != 2'd2) begin
                            colour <= colour + 2'd1;
                        end else begin
                            colour <= '0;
                            if (plane != PLW'(COLOR_BITS - 1)) begin
                                plane <= plane + PLW'(1);
                            end else begin
                                plane <= '0;
                                if (row != RW'(ROWS - 1)) begin
                                    row <= row + RW'(1);
                                end else begin
                                    row          <= '0;
                                    o_frame_done <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_bcm.sv
// tb_matrix_bcm: directed checks of the matrix driver. A pin monitor rebuilds
// each shifted word (first bit = index 0) and timestamps latch/frame events.
module tb_matrix_bcm;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  clk_div;
    logic        mode;
    logic        mclk, mlatch, mosi, fdone;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_stall;
    logic [5:0]  wb_addr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_wdata, wb_rdata;
    // small 3x3 instance exercises out-of-range addresses
    logic        s_mclk, s_mlatch, s_mosi, s_fdone;
    logic        s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [3:0]  s_addr;
    logic [3:0]  s_sel;
    logic [31:0] s_wdata, s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_bcm dut (
        .clk(clk), .reset_n(reset_n), .i_clk_div(clk_div), .i_mode(mode),
        .o_matrix_clk(mclk), .o_matrix_latch(mlatch), .o_matrix_mosi(mosi),
        .o_frame_done(fdone), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_sel(wb_sel), .i_wb_wdata(wb_wdata),
        .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_rdata(wb_rdata)
    );

    matrix_bcm #(.ROWS(3), .COLS(3)) sdut (
        .clk(clk), .reset_n(reset_n), .i_clk_div(clk_div), .i_mode(mode),
        .o_matrix_clk(s_mclk), .o_matrix_latch(s_mlatch), .o_matrix_mosi(s_mosi),
        .o_frame_done(s_fdone), .i_wb_cyc(s_cyc), .i_wb_stb(s_stb), .i_wb_we(s_we),
        .i_wb_addr(s_addr), .i_wb_sel(s_sel), .i_wb_wdata(s_wdata),
        .o_wb_ack(s_ack), .o_wb_stall(s_stall), .o_wb_rdata(s_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pin monitor
    int          cyc = 0;
    int          bitn = 0;
    logic [63:0] cur = '0;
    logic [63:0] words[$];
    int          nbits[$];
    int          lat[$];
    int          clk_rise[$];
    int          fd_lat[$];
    int          lat_w = -1;
    logic        p_mclk = 1'b0, p_latch = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
            bitn = 0; cur = '0; lat_w = -1;
            words.delete(); nbits.delete(); lat.delete(); clk_rise.delete(); fd_lat.delete();
        end else begin
            if (mclk && !p_mclk) begin
                if (bitn < 64) cur[bitn] = mosi;
                bitn++;
                if (clk_rise.size() < 2) clk_rise.push_back(cyc);
            end
            if (mlatch && !p_latch) begin
                words.push_back(cur); nbits.push_back(bitn); lat.push_back(cyc);
                bitn = 0; cur = '0;
            end
            if (!mlatch && p_latch && lat_w < 0 && lat.size() > 0) lat_w = cyc - lat[0];
            if (fdone) fd_lat.push_back(words.size());
        end
        p_mclk = mclk; p_latch = mlatch;
    end

    function automatic logic [31:0] wd(input int i);
        return (i < words.size()) ? words[i][31:0] : 32'hxxxx_xxxx;
    endfunction

    function automatic int lt(input int i);
        return (i < lat.size()) ? lat[i] : 0;
    endfunction

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (words.size() < n && k < budget) begin @(negedge clk); k++; end
        if (words.size() < n) chk("wait_words", words.size(), n);
    endtask

    task automatic wb(input bit sm, input bit we, input int a, input logic [3:0] sel,
                      input logic [31:0] d, output logic [31:0] rd, output logic ack);
        @(negedge clk);
        if (sm) begin s_cyc = 1; s_stb = 1; s_we = we; s_addr = 4'(a); s_sel = sel; s_wdata = d; end
        else begin wb_cyc = 1; wb_stb = 1; wb_we = we; wb_addr = 6'(a); wb_sel = sel; wb_wdata = d; end
        @(negedge clk);
        ack = sm ? s_ack : wb_ack;
        rd  = sm ? s_rdata : wb_rdata;
        s_cyc = 0; s_stb = 0; s_we = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    logic [31:0] rd;
    logic        ack;

    initial begin
        clk_div = 8'd3; mode = 1'b1;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = '0; wb_sel = '0; wb_wdata = '0;
        s_cyc = 0; s_stb = 0; s_we = 0; s_addr = '0; s_sel = '0; s_wdata = '0;

        // reset state
        repeat (4) @(negedge clk);
        chk("rst_mosi", mosi, 1);
        chk("rst_clk", mclk, 0);
        chk("rst_latch", mlatch, 0);
        chk("rst_fd", fdone, 0);
        chk("rst_ack", wb_ack, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_rdata", wb_rdata, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // mode 1, pixel 0 red at full scale
        wb(0, 1, 0, 4'hF, 32'h0000_000F, rd, ack);
        chk("wr_ack", ack, 1);
        wb(0, 1, 9, 4'hF, 32'h0000_00A0, rd, ack);
        wb(0, 0, 0, 4'h0, 32'h0, rd, ack);
        chk("rd_px0", rd, 32'h00F);
        chk("rd_ack", ack, 1);
        @(negedge clk);
        chk("ack_drop", wb_ack, 0);

        wait_words(6, 4000);
        chk("blank_nbits", (nbits.size() > 0) ? nbits[0] : -1, 32);
        chk("blank_word", wd(0), 32'h00FF_FFFF);
        chk("mclk_period", (clk_rise.size() == 2) ? clk_rise[1] - clk_rise[0] : -1, 8);
        chk("latch_width", lat_w, 4);
        for (int p = 0; p < 4; p++)
            chk($sformatf("r0_m1_p%0d", p), wd(1 + p), 32'h01FF_FFFE);
        // blank latch has no hold before the next shift, so it is the zero reference
        for (int p = 0; p < 4; p++)
            chk($sformatf("hold_p%0d", p), (lt(p + 2) - lt(p + 1)) - (lt(1) - lt(0)), 64 << p);

        // two frames: blank + 32 latches per frame in mode 1
        begin
            int k = 0;
            while (fd_lat.size() < 2 && k < 40000) begin @(negedge clk); k++; end
        end
        chk("fd_count", fd_lat.size(), 2);
        chk("fd_first", (fd_lat.size() > 0) ? fd_lat[0] : -1, 33);
        chk("fd_second", (fd_lat.size() > 1) ? fd_lat[1] : -1, 65);

        // mode 0: G=1010 at row1 col1 lights only in G pass of planes 1 and 3
        reset_n = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        wb(0, 1, 9, 4'hF, 32'h0000_00A0, rd, ack);
        wait_words(25, 20000);
        chk("r0_m0_off", wd(1), 32'h01FF_FFFF);
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 3; c++) begin
                logic [31:0] e;
                e = 32'h02FF_FFFF;
                if (c == 2 && (p == 1 || p == 3)) e = 32'h02FD_FFFF;
                chk($sformatf("r1_m0_p%0d_c%0d", p, c), wd(13 + p * 3 + c), e);
            end

        // byte enables and discarded upper bits
        wb(0, 1, 5, 4'h1, 32'h0000_0FFF, rd, ack);
        wb(0, 0, 5, 4'h0, 32'h0, rd, ack);
        chk("sel_byte0", rd, 32'h0FF);
        wb(0, 1, 6, 4'hF, 32'hFFFF_FFFF, rd, ack);
        wb(0, 0, 6, 4'h0, 32'h0, rd, ack);
        chk("upper_drop", rd, 32'hFFF);

        // out-of-range address on 3x3 instance
        wb(1, 1, 12, 4'hF, 32'h0000_0555, rd, ack);
        chk("oor_wr_ack", ack, 1);
        wb(1, 0, 12, 4'h0, 32'h0, rd, ack);
        chk("oor_rd", rd, 0);
        chk("oor_rd_ack", ack, 1);
        wb(1, 1, 8, 4'hF, 32'h0000_0123, rd, ack);
        wb(1, 0, 8, 4'h0, 32'h0, rd, ack);
        chk("s_last_px", rd, 32'h123);

        // reset while shifting: pins drop at once, scan restarts with blank word
        begin
            int k = 0;
            while (!(mclk && !mosi) && k < 2000) begin @(negedge clk); k++; end
        end
        chk("midshift_seen", {31'd0, mclk && !mosi}, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_mosi", mosi, 1);
        chk("mid_rst_clk", mclk, 0);
        chk("mid_rst_latch", mlatch, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_words(1, 1000);
        chk("restart_blank", wd(0), 32'h00FF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
